// File: rtl/traffic_light_cntrl_multi_pkg.sv
// Shared types for the multi-approach traffic controller: phase encoding,
// per-approach light codes and the round-robin demand search.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10,
        FLASH   = 2'b11
    } phase_e;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;
    localparam logic [1:0] LT_OFF    = 2'b11;

    localparam int MAX_DIR = 32;

    // Scanning from the far end means the last hit wins, i.e. the approach
    // closest after cur in round-robin order. Returns -1 when nobody waits.
    function automatic int next_request(input logic [MAX_DIR-1:0] req,
                                        input int cur,
                                        input int num_dir);
        int result;
        int d;
        result = -1;
        for (int i = MAX_DIR; i >= 1; i--) begin
            if (i <= num_dir) begin
                d = (cur + i) % num_dir;
                if (req[d[4:0]]) begin
                    result = d;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/traffic_light_cntrl_multi_timer.sv
// Prescaled seconds timer: one-cycle sec_tick every TICK_DIV clocks and a
// saturating seconds count, both cleared together on clear.
module sec_tick_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SEC_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic             sec_tick,
    output logic [SEC_W-1:0] seconds
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescale;

    assign sec_tick = (prescale == PW'(TICK_DIV - 1));

    // Saturation keeps an indefinitely held green from wrapping back below
    // its minimum duration.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prescale <= '0;
            seconds  <= '0;
        end else if (sec_tick) begin
            prescale <= '0;
            if (seconds != '1) begin
                seconds <= seconds + SEC_W'(1);
            end
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_light_cntrl_multi.sv
// Round-robin controller for NUM_DIR approaches with demand skip, green hold
// and flashing-yellow mode; all outputs come straight from registers.
module traffic_light_cntrl_multi
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int GREEN_SEC  = 5,
    parameter int YELLOW_SEC = 2,
    parameter int ALLRED_SEC = 1,
    parameter int SKIP_EN    = 1,
    parameter int SEC_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_DIR-1:0]         car_present,
    input  logic                       flash_mode,
    output logic [2*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [1:0]                 phase
);

    localparam int DW = $clog2(NUM_DIR);

    phase_e             state;
    phase_e             state_nxt;
    logic [DW-1:0]      dir_nxt;
    logic               clear;
    logic               sec_tick;
    logic [SEC_W-1:0]   seconds;
    logic               flash_yel;
    logic               flash_yel_nxt;
    logic [MAX_DIR-1:0] demand;
    logic [MAX_DIR-1:0] others;
    int                 req_dir;
    logic               green_done;
    logic               yellow_done;
    logic               allred_done;

    sec_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .SEC_W    (SEC_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .sec_tick (sec_tick),
        .seconds  (seconds)
    );

    assign green_done  = sec_tick && (int'(seconds) >= GREEN_SEC - 1);
    assign yellow_done = sec_tick && (int'(seconds) >= YELLOW_SEC - 1);
    assign allred_done = sec_tick && (int'(seconds) >= ALLRED_SEC - 1);
    assign phase       = state;

    function automatic logic [2*NUM_DIR-1:0] decode(input phase_e p,
                                                    input logic [DW-1:0] d,
                                                    input logic yel);
        logic [2*NUM_DIR-1:0] l;
        l = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            case (p)
                GREEN:   if (d == DW'(i)) l[2*i +: 2] = LT_GREEN;
                YELLOW:  if (d == DW'(i)) l[2*i +: 2] = LT_YELLOW;
                FLASH:   l[2*i +: 2] = yel ? LT_YELLOW : LT_OFF;
                default: l[2*i +: 2] = LT_RED;
            endcase
        end
        return l;
    endfunction

    // The timer clear is decided here so it lands on the same edge as the
    // phase change; an all-red re-evaluation with no demand also restarts it.
    always_comb begin
        demand                = '0;
        demand[NUM_DIR-1:0]   = car_present;
        others                = demand;
        others[active_dir]    = 1'b0;
        req_dir = (SKIP_EN != 0) ? next_request(demand, int'(active_dir), NUM_DIR)
                                 : (int'(active_dir) + 1) % NUM_DIR;
        state_nxt     = state;
        dir_nxt       = active_dir;
        clear         = 1'b0;
        flash_yel_nxt = flash_yel;
        if (flash_mode) begin
            if (state != FLASH) begin
                state_nxt     = FLASH;
                clear         = 1'b1;
                flash_yel_nxt = 1'b1;
            end else if (sec_tick) begin
                flash_yel_nxt = ~flash_yel;
            end
        end else begin
            unique case (state)
                FLASH: begin
                    state_nxt = ALL_RED;
                    clear     = 1'b1;
                end
                ALL_RED: if (allred_done) begin
                    clear = 1'b1;
                    if (req_dir >= 0) begin
                        state_nxt = GREEN;
                        dir_nxt   = DW'(req_dir);
                    end
                end
                GREEN: if (green_done && (SKIP_EN == 0 || (|others))) begin
                    state_nxt = YELLOW;
                    clear     = 1'b1;
                end
                YELLOW: if (yellow_done) begin
                    state_nxt = ALL_RED;
                    clear     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ALL_RED;
            active_dir <= DW'(NUM_DIR - 1);
            flash_yel  <= 1'b1;
            lights     <= '0;
        end else begin
            state      <= state_nxt;
            active_dir <= dir_nxt;
            flash_yel  <= flash_yel_nxt;
            lights     <= decode(state_nxt, dir_nxt, flash_yel_nxt);
        end
    end

    function automatic int count_lit(input logic [2*NUM_DIR-1:0] l);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (l[2*i +: 2] != LT_RED) n++;
        end
        return n;
    endfunction

    a_one_lit: assert property (@(posedge clk) disable iff (reset)
        (state != FLASH) |-> (count_lit(lights) <= 1));

endmodule
